// File: rtl/sram_pkg.sv
// Shared types and widths for the SRAM arbiter.
// Imported by the arbiter top and its round-robin grant helper.
package sram_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_e;

  typedef enum logic {
    CPU = 1'b0,
    LDR = 1'b1
  } port_e;

endpackage

// File: rtl/sram_arbiter_rr.sv
// Two-requester alternating-priority grant.
// The last-served port loses a tie; reset makes the loader last-served.
module rr_arbiter2
  import sram_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output port_e      gnt_o
);

  port_e last_q, last_d;

  always_comb begin
    gnt_o = CPU;
    unique case (req_i)
      2'b11:   gnt_o = (last_q == LDR) ? CPU : LDR;
      2'b10:   gnt_o = LDR;
      default: gnt_o = CPU;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (take_i) last_d = gnt_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= LDR;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between a CPU port and a loader port.
// All strobes and the bus drive-enable come straight from flops.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ready,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic              UB,
  output logic              LB,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] Data
);

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  port_e sel_q, sel_d, gnt;
  logic wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic ce_q, ce_d, oe_q, oe_d;
  logic we_q, we_d, bs_q;
  logic drv_q, drv_d;
  logic crdy_q, crdy_d, lrdy_q, lrdy_d;
  logic [DATA_W-1:0] crd_q, crd_d;
  logic [DATA_W-1:0] lrd_q, lrd_d;
  logic take, last_acc, busy_d;

  rr_arbiter2 u_arb (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .req_i  ({ldr_req, cpu_req}),
    .take_i (take),
    .gnt_o  (gnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req || ldr_req) begin
          take    = 1'b1;
          sel_d   = gnt;
          state_d = SETUP;
          if (gnt == LDR) begin
            wr_d    = ldr_we;
            addr_d  = ldr_addr;
            wdata_d = ldr_wdata;
          end else begin
            wr_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are precomputed from the next state so they flop in with it.
  always_comb begin
    last_acc = (state_q == ACCESS) && (cnt_q == '0);
    busy_d   = (state_d == SETUP) || (state_d == ACCESS);
    ce_d     = !busy_d;
    oe_d     = !(busy_d && !wr_d);
    we_d     = !((state_d == ACCESS) && wr_d);
    drv_d    = busy_d && wr_d;
    crdy_d   = (state_d == DONE) && (sel_d == CPU);
    lrdy_d   = (state_d == DONE) && (sel_d == LDR);
    crd_d    = crd_q;
    lrd_d    = lrd_q;
    if (last_acc && !wr_q) begin
      if (sel_q == CPU) crd_d = Data;
      else              lrd_d = Data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= CPU;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      bs_q    <= 1'b1;
      drv_q   <= 1'b0;
      crdy_q  <= 1'b0;
      lrdy_q  <= 1'b0;
      crd_q   <= '0;
      lrd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      bs_q    <= ce_d;
      drv_q   <= drv_d;
      crdy_q  <= crdy_d;
      lrdy_q  <= lrdy_d;
      crd_q   <= crd_d;
      lrd_q   <= lrd_d;
    end
  end

  assign CE        = ce_q;
  assign OE        = oe_q;
  assign WE        = we_q;
  assign UB        = bs_q;
  assign LB        = bs_q;
  assign ADDR      = addr_q;
  assign Data      = drv_q ? wdata_q : {DATA_W{1'bz}};
  assign cpu_ready = crdy_q;
  assign ldr_ready = lrdy_q;
  assign cpu_rdata = crd_q;
  assign ldr_rdata = lrd_q;

endmodule
